// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing shared by the timing generator and the renderer
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster position, sync and strobe bundle from the timing generator to its consumers
interface vga_timing_if;
    import vga_pkg::*;
    coord_t sx;
    coord_t sy;
    logic active_pixel;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
    logic [15:0] frame_count;
    modport master (output sx, sy, active_pixel, hsync, vsync, line_start, frame_start, frame_count);
    modport slave (input sx, sy, active_pixel, hsync, vsync, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; wrapping position counter with active/sync decodes of its next value
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = H_TOTAL,
    parameter int ACT = H_ACTIVE,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END = H_SYNC_END
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    output coord_t value,
    output logic   wrap,
    output logic   act_nxt_o,
    output logic   sync_nxt_o
);
    coord_t value_q, value_d;
    if (TOTAL < 2 || TOTAL > 2 ** COORD_W) begin : g_total_check
        $error("vga_axis_counter: TOTAL must be within 2..1024");
    end
    // next position plus decodes of it, so the top can register them alongside the position
    always_comb begin
        wrap = inc && int'(value_q) == TOTAL - 1;
        value_d = inc ? (wrap ? '0 : value_q + 1'b1) : value_q;
        act_nxt_o = int'(value_d) < ACT;
        sync_nxt_o = int'(value_d) >= SYNC_START && int'(value_d) < SYNC_END;
    end
    // position register
    always_ff @(posedge clk) begin
        if (rst) value_q <= '0;
        else value_q <= value_d;
    end
    assign value = value_q;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator; every output registered on the same edge as the coordinates it describes
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP = vga_pkg::V_BP,
    parameter bit H_POL = 1'b0,
    parameter bit V_POL = 1'b0
) (
    input logic clk_25,
    input logic rst,
    vga_timing_if.master vga_o
);
    coord_t h_value, v_value;
    logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    vga_axis_counter #(
        .TOTAL(H_ACTIVE + H_FP + H_SYNC + H_BP),
        .ACT(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END(H_ACTIVE + H_FP + H_SYNC)
    ) u_h (
        .clk(clk_25), .rst(rst), .inc(1'b1), .value(h_value), .wrap(h_wrap),
        .act_nxt_o(h_act), .sync_nxt_o(h_sync)
    );
    vga_axis_counter #(
        .TOTAL(V_ACTIVE + V_FP + V_SYNC + V_BP),
        .ACT(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END(V_ACTIVE + V_FP + V_SYNC)
    ) u_v (
        .clk(clk_25), .rst(rst), .inc(h_wrap), .value(v_value), .wrap(v_wrap),
        .act_nxt_o(v_act), .sync_nxt_o(v_sync)
    );
    // a horizontal wrap lands on sx=0; a vertical wrap (only possible on a horizontal one) lands on (0,0)
    always_comb begin
        active_d = h_act && v_act;
        hsync_d = h_sync ? H_POL : ~H_POL;
        vsync_d = v_sync ? V_POL : ~V_POL;
        line_start_d = h_wrap;
        frame_start_d = v_wrap;
        frame_count_d = frame_count_q + 16'(v_wrap);
    end
    // decode registers, reset to the idle levels so release never produces a partial strobe
    always_ff @(posedge clk_25) begin
        if (rst) begin
            active_q <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            line_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            active_q <= active_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_start_q <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end
    assign vga_o.sx = h_value;
    assign vga_o.sy = v_value;
    assign vga_o.active_pixel = active_q;
    assign vga_o.hsync = hsync_q;
    assign vga_o.vsync = vsync_q;
    assign vga_o.line_start = line_start_q;
    assign vga_o.frame_start = frame_start_q;
    assign vga_o.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default-timing and shrunken-timing generators against a cycle-count raster model
module tb_vga_timing;
    import vga_pkg::*;
    localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;
    localparam int BVA = 12, BVF = 2, BVS = 3, BVB = 4;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    int vectors = 0, miscompares = 0;
    int n_a = 0, n_b = 0;
    bit r_a = 1'b1, r_b = 1'b1, live = 1'b0;
    logic [15:0] fc_prev;
    vga_timing_if ifa ();
    vga_timing_if ifb ();
    always #20 clk = ~clk;
    vga_timing dut_a (.clk_25(clk), .rst(rst_a), .vga_o(ifa));
    vga_timing #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut_b (.clk_25(clk), .rst(rst_b), .vga_o(ifb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // the raster is fully determined by the clocks elapsed since the last reset edge
    task automatic check_raster(input string id, input int n, input bit r,
                                input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp,
                                input logic [9:0] sx, sy, input logic act, hsy, vsy, ls, fs,
                                input logic [15:0] fc);
        int ht, vt, x, y;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        x = n % ht;
        y = (n / ht) % vt;
        check({id, ".sx"}, 32'(sx), 32'(x));
        check({id, ".sy"}, 32'(sy), 32'(y));
        check({id, ".frame_count"}, 32'(fc), 32'((n / (ht * vt)) % 65536));
        check({id, ".active_pixel"}, 32'(act), 32'(!r && x < ha && y < va));
        check({id, ".hsync"}, 32'(hsy), 32'((!r && x >= ha + hf && x < ha + hf + hs) ? hp : !hp));
        check({id, ".vsync"}, 32'(vsy), 32'((!r && y >= va + vf && y < va + vf + vs) ? vp : !vp));
        check({id, ".line_start"}, 32'(ls), 32'(!r && x == 0));
        check({id, ".frame_start"}, 32'(fs), 32'(!r && x == 0 && y == 0));
    endtask

    task automatic wait_b(input int x, input int y);
        int k = 0;
        while (!(32'(ifb.sx) == x && 32'(ifb.sy) == y) && k < 4 * BHT * BVT) begin
            @(negedge clk);
            k++;
        end
        check("wait_b_position", 32'(k < 4 * BHT * BVT), 32'd1);
    endtask

    always @(posedge clk) begin
        if (rst_a) begin n_a = 0; r_a = 1'b1; end
        else begin n_a++; r_a = 1'b0; end
        if (rst_b) begin n_b = 0; r_b = 1'b1; end
        else begin n_b++; r_b = 1'b0; end
    end

    always @(negedge clk) begin
        if (live) begin
            check_raster("a", n_a, r_a, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP,
                         1'b0, 1'b0, ifa.sx, ifa.sy, ifa.active_pixel, ifa.hsync, ifa.vsync,
                         ifa.line_start, ifa.frame_start, ifa.frame_count);
            check_raster("b", n_b, r_b, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB,
                         1'b1, 1'b0, ifb.sx, ifb.sy, ifb.active_pixel, ifb.hsync, ifb.vsync,
                         ifb.line_start, ifb.frame_start, ifb.frame_count);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        live = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("release.sx", 32'(ifa.sx), 32'd1);
        check("release.sy", 32'(ifa.sy), 32'd0);
        check("release.active_pixel", 32'(ifa.active_pixel), 32'd1);
        check("release.hsync", 32'(ifa.hsync), 32'd1);
        check("release.vsync", 32'(ifa.vsync), 32'd1);
        check("release.frame_start", 32'(ifa.frame_start), 32'd0);
        @(negedge clk);
        wait_b(BHT - 1, BVT - 1);
        fc_prev = ifb.frame_count;
        @(negedge clk);
        check("wrap.sx", 32'(ifb.sx), 32'd0);
        check("wrap.sy", 32'(ifb.sy), 32'd0);
        check("wrap.frame_start", 32'(ifb.frame_start), 32'd1);
        check("wrap.line_start", 32'(ifb.line_start), 32'd1);
        check("wrap.frame_count", 32'(ifb.frame_count), 32'(fc_prev + 16'd1));
        wait_b(13, 7);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("midrst.sx", 32'(ifb.sx), 32'd0);
        check("midrst.sy", 32'(ifb.sy), 32'd0);
        check("midrst.frame_count", 32'(ifb.frame_count), 32'd0);
        check("midrst.hsync", 32'(ifb.hsync), 32'd0);
        check("midrst.line_start", 32'(ifb.line_start), 32'd0);
        @(negedge clk);
        check("resume.sx", 32'(ifb.sx), 32'd1);
        check("resume.sy", 32'(ifb.sy), 32'd0);
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            rst_b = $urandom_range(0, 3999) == 0;
            rst_a = $urandom_range(0, 19999) == 0;
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
